// File: rtl/clk_gen_multi.sv
// clk_gen_multi: independent programmable clock dividers with clean stop,
// double-buffered divisors and a shared phase-realign strobe.
module clk_gen_multi #(
  parameter  int Channels   = 2,
  parameter  int DivWidth   = 16,
  parameter  int DefaultDiv = 0,
  localparam int ChanW      = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                _iClk,
  input  logic                _iRst,
  input  logic [Channels-1:0] _iEn,
  input  logic                _iWrEn,
  input  logic [ChanW-1:0]    _iWrChan,
  input  logic [DivWidth-1:0] _iWrDiv,
  input  logic                _iSync,
  output logic [Channels-1:0] _oClk,
  output logic [Channels-1:0] _oTick
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } chanState_t;

  localparam logic [DivWidth-1:0] ResetDiv = DivWidth'(DefaultDiv);

  for (genvar c = 0; c < Channels; c++) begin : gChan
    chanState_t          state, stateN;
    logic [DivWidth-1:0] pend, pendN;
    logic [DivWidth-1:0] act, actN;
    logic [DivWidth-1:0] cnt, cntN;
    logic                clkR, clkN;
    logic                tickR, tickN;
    logic                wrHit, term, en;
    logic [DivWidth-1:0] nextDiv;

    assign en      = _iEn[c];
    assign wrHit   = _iWrEn && (int'(_iWrChan) == c);
    assign term    = (cnt == act);
    // a write landing on a reload cycle goes straight to active
    assign nextDiv = wrHit ? _iWrDiv : pend;

    always_ff @(posedge _iClk) begin
      if (_iRst) begin
        state <= IDLE;
        pend  <= ResetDiv;
        act   <= ResetDiv;
        cnt   <= '0;
        clkR  <= 1'b0;
        tickR <= 1'b0;
      end else begin
        state <= stateN;
        pend  <= pendN;
        act   <= actN;
        cnt   <= cntN;
        clkR  <= clkN;
        tickR <= tickN;
      end
    end

    always_comb begin
      stateN = state;
      pendN  = wrHit ? _iWrDiv : pend;
      actN   = act;
      cntN   = cnt;
      clkN   = clkR;
      tickN  = 1'b0;
      unique case (state)
        IDLE: begin
          cntN = '0;
          clkN = 1'b0;
          if (en) begin
            stateN = RUN;
            actN   = pend;
          end
        end
        RUN, STOPPING: begin
          if (_iSync) begin
            cntN   = '0;
            clkN   = 1'b0;
            actN   = nextDiv;
            stateN = (state == RUN && en) ? RUN : IDLE;
          end else if (state == RUN && !en && !clkR) begin
            stateN = IDLE;
            cntN   = '0;
          end else if (term) begin
            clkN   = !clkR;
            tickN  = !clkR;
            cntN   = '0;
            actN   = nextDiv;
            stateN = en ? RUN : IDLE;
          end else begin
            cntN   = cnt + DivWidth'(1);
            stateN = en ? RUN : STOPPING;
          end
        end
        default: begin
          stateN = IDLE;
          cntN   = '0;
          clkN   = 1'b0;
        end
      endcase
    end

    assign _oClk[c]  = clkR;
    assign _oTick[c] = tickR;
  end

endmodule
